// File: rtl/gray_frame_packer.sv
// Packs gray pixel pairs into 16-bit words tagged with frame word address and SOF/EOF,
// buffered in a show-ahead FIFO drained over valid/ready.
module gray_frame_packer #(
  parameter int unsigned FRAME_W    = 640,
  parameter int unsigned FRAME_H    = 480,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        iCLK,
  input  logic                        iReset_n,
  input  logic [7:0]                  iGray,
  input  logic                        iDval,
  input  logic [15:0]                 iX_Cont,
  input  logic [15:0]                 iY_Cont,
  input  logic                        iClrErr,
  output logic [15:0]                 oData,
  output logic [ADDR_W-1:0]           oAddr,
  output logic                        oSOF,
  output logic                        oEOF,
  output logic                        oValid,
  input  logic                        iReady,
  output logic                        oFrameDone,
  output logic                        oOverflow,
  output logic                        oSyncErr,
  output logic [$clog2(FIFO_DEPTH):0] oLevel
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = ADDR_W + 18;
  localparam logic [15:0] W16    = 16'(FRAME_W);
  localparam logic [15:0] H16    = 16'(FRAME_H);
  localparam logic [15:0] LAST_X = 16'(FRAME_W - 1);
  localparam logic [15:0] LAST_Y = 16'(FRAME_H - 1);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(FIFO_DEPTH);

  // Stage 1 registers
  logic [7:0]  r_gray;
  logic        r_dval;
  logic [15:0] r_x;
  logic [15:0] r_y;

  // Pack state
  logic              r_pend;
  logic [7:0]        r_pend_pix;
  logic              r_sof_pend;
  logic [ADDR_W-1:0] r_addr;

  // FIFO state
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_level;
  logic          r_done;
  logic          r_ovf;
  logic          r_sync;

  logic              w_in_range;
  logic              w_push_req;
  logic              w_sync_set;
  logic              w_pend_nxt;
  logic [7:0]        w_pix_nxt;
  logic              w_sofp_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [EW-1:0]     w_entry;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_ovf_set;
  logic [EW-1:0]     w_head;

  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      r_gray <= '0;
      r_dval <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
    end else begin
      r_gray <= iGray;
      r_dval <= iDval;
      r_x    <= iX_Cont;
      r_y    <= iY_Cont;
    end
  end

  assign w_in_range = r_dval && (r_x < W16) && (r_y < H16);

  // Frame start is tested before parity so a stale pending pixel is discarded silently.
  always_comb begin
    w_push_req = 1'b0;
    w_sync_set = 1'b0;
    w_pend_nxt = r_pend;
    w_pix_nxt  = r_pend_pix;
    w_sofp_nxt = r_sof_pend;
    w_addr_nxt = r_addr;
    w_entry    = {r_sof_pend, (r_x == LAST_X) && (r_y == LAST_Y), r_addr, r_gray, r_pend_pix};
    if (w_in_range) begin
      if (r_x == '0 && r_y == '0) begin
        w_addr_nxt = '0;
        w_pend_nxt = 1'b1;
        w_pix_nxt  = r_gray;
        w_sofp_nxt = 1'b1;
      end else if (!r_x[0]) begin
        w_sync_set = r_pend;
        w_pend_nxt = 1'b1;
        w_pix_nxt  = r_gray;
      end else if (r_pend) begin
        w_push_req = 1'b1;
        w_addr_nxt = r_addr + 1'b1;
        w_pend_nxt = 1'b0;
        w_sofp_nxt = 1'b0;
      end else begin
        w_sync_set = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      r_pend     <= 1'b0;
      r_pend_pix <= '0;
      r_sof_pend <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_pix <= w_pix_nxt;
      r_sof_pend <= w_sofp_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  assign w_valid   = (r_level != '0);
  assign w_pop     = w_valid && iReady;
  assign w_push    = w_push_req && ((r_level != FULL_LVL) || w_pop);
  assign w_ovf_set = w_push_req && !w_push;
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge iCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_sync   <= 1'b0;
    end else begin
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_done <= w_pop & w_head[EW-2];
      r_ovf  <= w_ovf_set  | (r_ovf  & ~iClrErr);
      r_sync <= w_sync_set | (r_sync & ~iClrErr);
    end
  end

  // Head fields are masked so every output reads 0 while the FIFO is empty.
  always_comb begin
    oData = '0;
    oAddr = '0;
    oSOF  = 1'b0;
    oEOF  = 1'b0;
    if (w_valid) begin
      oData = w_head[15:0];
      oAddr = w_head[EW-3:16];
      oSOF  = w_head[EW-1];
      oEOF  = w_head[EW-2];
    end
  end

  assign oValid     = w_valid;
  assign oLevel     = r_level;
  assign oFrameDone = r_done;
  assign oOverflow  = r_ovf;
  assign oSyncErr   = r_sync;

endmodule

// File: tb/tb_gray_frame_packer.sv
// Directed bench for gray_frame_packer with a 4x2 frame and a 16-entry FIFO.
module tb_gray_frame_packer;

  typedef logic [35:0] word_t;  // {sof, eof, addr[17:0], data[15:0]}

  logic        iCLK = 1'b0;
  logic        iReset_n = 1'b0;
  logic [7:0]  iGray = '0;
  logic        iDval = 1'b0;
  logic [15:0] iX_Cont = '0;
  logic [15:0] iY_Cont = '0;
  logic        iClrErr = 1'b0;
  logic        iReady = 1'b0;
  logic [15:0] oData;
  logic [17:0] oAddr;
  logic        oSOF, oEOF, oValid, oFrameDone, oOverflow, oSyncErr;
  logic [4:0]  oLevel;

  int    n_pass = 0;
  int    n_total = 0;
  int    n_done = 0;
  word_t mon_q[$];

  gray_frame_packer #(.FRAME_W(4), .FRAME_H(2), .ADDR_W(18), .FIFO_DEPTH(16)) dut (
    .iCLK(iCLK), .iReset_n(iReset_n), .iGray(iGray), .iDval(iDval),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iClrErr(iClrErr),
    .oData(oData), .oAddr(oAddr), .oSOF(oSOF), .oEOF(oEOF), .oValid(oValid),
    .iReady(iReady), .oFrameDone(oFrameDone), .oOverflow(oOverflow),
    .oSyncErr(oSyncErr), .oLevel(oLevel)
  );

  always #5 iCLK = ~iCLK;

  // Transfer log: samples mid-cycle, just before the edge that pops.
  always @(negedge iCLK) begin
    #1;
    if (iReset_n && oValid && iReady) mon_q.push_back({oSOF, oEOF, oAddr, oData});
    if (oFrameDone) n_done++;
  end

  task automatic drive_pix(input int x, input int y, input logic [7:0] g);
    @(negedge iCLK);
    iDval = 1'b1; iX_Cont = 16'(x); iY_Cont = 16'(y); iGray = g;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iCLK);
      iDval = 1'b0;
    end
  endtask

  task automatic test_reset;
    #3;
    n_total++; if (oValid !== 1'b0) $display("FAIL rst_valid: got %b want 0", oValid); else n_pass++;
    n_total++; if (oLevel !== 5'd0) $display("FAIL rst_level: got %0d want 0", oLevel); else n_pass++;
    repeat (2) @(negedge iCLK);
    n_total++; if (oOverflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", oOverflow); else n_pass++;
    n_total++; if (oSyncErr !== 1'b0) $display("FAIL rst_sync: got %b want 0", oSyncErr); else n_pass++;
    n_total++; if (oFrameDone !== 1'b0) $display("FAIL rst_done: got %b want 0", oFrameDone); else n_pass++;
    n_total++; if ({oSOF, oEOF, oAddr, oData} !== 36'd0)
      $display("FAIL rst_head: got %h want 0", {oSOF, oEOF, oAddr, oData}); else n_pass++;
    iReset_n = 1'b1;
  endtask

  task automatic test_full_frame;
    word_t exp_w[4] = '{{1'b1, 1'b0, 18'd0, 16'h1110}, {1'b0, 1'b0, 18'd1, 16'h1312},
                        {1'b0, 1'b0, 18'd2, 16'h1514}, {1'b0, 1'b1, 18'd3, 16'h1716}};
    iReady = 1'b1; mon_q.delete(); n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge iCLK);
      if (i == 2) begin
        n_total++; if (oValid !== 1'b0) $display("FAIL ff_lat_early: got %b want 0", oValid); else n_pass++;
      end
      if (i == 3) begin
        n_total++; if (oValid !== 1'b1) $display("FAIL ff_lat_valid: got %b want 1", oValid); else n_pass++;
        n_total++; if (oData !== 16'h1110) $display("FAIL ff_lat_data: got %h want 1110", oData); else n_pass++;
      end
      iDval = 1'b1; iX_Cont = 16'(i % 4); iY_Cont = 16'(i / 4); iGray = 8'(8'h10 + i);
    end
    idle(6);
    n_total++; if (mon_q.size() !== 4) $display("FAIL ff_count: got %0d want 4", mon_q.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (mon_q[i] !== exp_w[i]) $display("FAIL ff_word%0d: got %h want %h", i, mon_q[i], exp_w[i]); else n_pass++;
    end
    n_total++; if (n_done !== 1) $display("FAIL ff_done: got %0d want 1", n_done); else n_pass++;
  endtask

  task automatic test_backpressure;
    word_t e;
    iReady = 1'b0; mon_q.delete(); n_done = 0;
    for (int p = 0; p < 40; p++) drive_pix(p % 4, (p < 4) ? 0 : 1, 8'(p));
    idle(3);
    n_total++; if (oLevel !== 5'd16) $display("FAIL bp_level: got %0d want 16", oLevel); else n_pass++;
    n_total++; if (oOverflow !== 1'b1) $display("FAIL bp_ovf: got %b want 1", oOverflow); else n_pass++;
    n_total++; if ({oSOF, oEOF, oAddr, oData} !== {1'b1, 1'b0, 18'd0, 16'h0100})
      $display("FAIL bp_head: got %h want %h", {oSOF, oEOF, oAddr, oData}, {1'b1, 1'b0, 18'd0, 16'h0100}); else n_pass++;
    idle(3);
    n_total++; if ({oValid, oData, oAddr} !== {1'b1, 16'h0100, 18'd0})
      $display("FAIL bp_hold: got %h want %h", {oValid, oData, oAddr}, {1'b1, 16'h0100, 18'd0}); else n_pass++;
    @(negedge iCLK); iReady = 1'b1;
    idle(20);
    n_total++; if (mon_q.size() !== 16) $display("FAIL bp_count: got %0d want 16", mon_q.size()); else n_pass++;
    for (int w = 0; w < 16; w++) begin
      e = {w == 0, (w >= 3) && (w % 2 == 1), 18'(w), 8'(2 * w + 1), 8'(2 * w)};
      n_total++; if (mon_q[w] !== e) $display("FAIL bp_word%0d: got %h want %h", w, mon_q[w], e); else n_pass++;
    end
    n_total++; if (n_done !== 7) $display("FAIL bp_done: got %0d want 7", n_done); else n_pass++;
    mon_q.delete();
    for (int x = 0; x < 4; x++) drive_pix(x, 1, 8'(8'h80 + x));
    idle(6);
    n_total++; if (mon_q.size() !== 2) $display("FAIL bp_after_count: got %0d want 2", mon_q.size()); else n_pass++;
    n_total++; if (mon_q[0] !== {1'b0, 1'b0, 18'd20, 16'h8180})
      $display("FAIL bp_skip_addr: got %h want %h", mon_q[0], {1'b0, 1'b0, 18'd20, 16'h8180}); else n_pass++;
    n_total++; if (mon_q[1] !== {1'b0, 1'b1, 18'd21, 16'h8382})
      $display("FAIL bp_skip_addr2: got %h want %h", mon_q[1], {1'b0, 1'b1, 18'd21, 16'h8382}); else n_pass++;
    mon_q.delete();
    for (int i = 0; i < 8; i++) drive_pix(i % 4, i / 4, 8'(8'hA0 + i));
    idle(6);
    n_total++; if (mon_q[0] !== {1'b1, 1'b0, 18'd0, 16'hA1A0})
      $display("FAIL bp_clean_first: got %h want %h", mon_q[0], {1'b1, 1'b0, 18'd0, 16'hA1A0}); else n_pass++;
    n_total++; if (mon_q[3] !== {1'b0, 1'b1, 18'd3, 16'hA7A6})
      $display("FAIL bp_clean_last: got %h want %h", mon_q[3], {1'b0, 1'b1, 18'd3, 16'hA7A6}); else n_pass++;
  endtask

  task automatic test_push_pop_full;
    @(negedge iCLK); iClrErr = 1'b1;
    @(negedge iCLK); iClrErr = 1'b0;
    n_total++; if (oOverflow !== 1'b0) $display("FAIL clr_ovf: got %b want 0", oOverflow); else n_pass++;
    iReady = 1'b0; mon_q.delete();
    for (int p = 0; p < 32; p++) drive_pix(p % 4, (p < 4) ? 0 : 1, 8'(p));
    idle(3);
    n_total++; if (oLevel !== 5'd16) $display("FAIL pp_prefill: got %0d want 16", oLevel); else n_pass++;
    drive_pix(0, 1, 8'hC0);
    drive_pix(1, 1, 8'hC1);
    @(negedge iCLK); iDval = 1'b0; iReady = 1'b1;
    @(negedge iCLK); iReady = 1'b0;
    n_total++; if (oLevel !== 5'd16) $display("FAIL pp_level: got %0d want 16", oLevel); else n_pass++;
    n_total++; if (oOverflow !== 1'b0) $display("FAIL pp_ovf: got %b want 0", oOverflow); else n_pass++;
    @(negedge iCLK); iReady = 1'b1;
    idle(22);
    n_total++; if (mon_q.size() !== 17) $display("FAIL pp_count: got %0d want 17", mon_q.size()); else n_pass++;
    n_total++; if (mon_q[0] !== {1'b1, 1'b0, 18'd0, 16'h0100})
      $display("FAIL pp_first: got %h want %h", mon_q[0], {1'b1, 1'b0, 18'd0, 16'h0100}); else n_pass++;
    n_total++; if (mon_q[16] !== {1'b0, 1'b0, 18'd16, 16'hC1C0})
      $display("FAIL pp_last: got %h want %h", mon_q[16], {1'b0, 1'b0, 18'd16, 16'hC1C0}); else n_pass++;
  endtask

  task automatic test_pairing;
    iReady = 1'b1; mon_q.delete();
    drive_pix(0, 0, 8'hA0); drive_pix(1, 0, 8'hA1);
    drive_pix(0, 1, 8'h40); drive_pix(2, 1, 8'h42); drive_pix(3, 1, 8'h43);
    idle(5);
    n_total++; if (oSyncErr !== 1'b1) $display("FAIL pair_even_even: got %b want 1", oSyncErr); else n_pass++;
    n_total++; if (mon_q.size() !== 2) $display("FAIL pair_count: got %0d want 2", mon_q.size()); else n_pass++;
    n_total++; if (mon_q[1] !== {1'b0, 1'b1, 18'd1, 16'h4342})
      $display("FAIL pair_word: got %h want %h", mon_q[1], {1'b0, 1'b1, 18'd1, 16'h4342}); else n_pass++;
    @(negedge iCLK); iClrErr = 1'b1;
    @(negedge iCLK); iClrErr = 1'b0;
    n_total++; if (oSyncErr !== 1'b0) $display("FAIL pair_clr: got %b want 0", oSyncErr); else n_pass++;
    mon_q.delete();
    drive_pix(1, 1, 8'h55);
    idle(4);
    n_total++; if (oSyncErr !== 1'b1) $display("FAIL pair_lone_odd: got %b want 1", oSyncErr); else n_pass++;
    n_total++; if (mon_q.size() !== 0) $display("FAIL pair_lone_drop: got %0d want 0", mon_q.size()); else n_pass++;
    @(negedge iCLK); iClrErr = 1'b1;
    @(negedge iCLK); iClrErr = 1'b0;
  endtask

  task automatic test_range_restart;
    iReady = 1'b1; mon_q.delete();
    drive_pix(0, 2, 8'h60); drive_pix(1, 2, 8'h61);
    drive_pix(4, 1, 8'h62); drive_pix(5, 1, 8'h63);
    idle(4);
    n_total++; if (mon_q.size() !== 0) $display("FAIL range_nopush: got %0d want 0", mon_q.size()); else n_pass++;
    n_total++; if (oSyncErr !== 1'b0) $display("FAIL range_noerr: got %b want 0", oSyncErr); else n_pass++;
    mon_q.delete();
    drive_pix(0, 0, 8'h70); drive_pix(1, 0, 8'h71); drive_pix(2, 0, 8'h72);
    drive_pix(0, 0, 8'h78); drive_pix(1, 0, 8'h79);
    idle(5);
    n_total++; if (mon_q.size() !== 2) $display("FAIL restart_count: got %0d want 2", mon_q.size()); else n_pass++;
    n_total++; if (mon_q[1] !== {1'b1, 1'b0, 18'd0, 16'h7978})
      $display("FAIL restart_word: got %h want %h", mon_q[1], {1'b1, 1'b0, 18'd0, 16'h7978}); else n_pass++;
    n_total++; if (oSyncErr !== 1'b0) $display("FAIL restart_noerr: got %b want 0", oSyncErr); else n_pass++;
  endtask

  task automatic test_async_reset;
    iReady = 1'b0; mon_q.delete();
    for (int i = 0; i < 8; i++) drive_pix(i % 4, i / 4, 8'(8'h30 + i));
    drive_pix(1, 1, 8'h3F);
    drive_pix(0, 1, 8'h3A); drive_pix(1, 1, 8'h3B);
    idle(3);
    n_total++; if (oLevel !== 5'd5) $display("FAIL ar_level_pre: got %0d want 5", oLevel); else n_pass++;
    n_total++; if (oSyncErr !== 1'b1) $display("FAIL ar_sync_pre: got %b want 1", oSyncErr); else n_pass++;
    @(negedge iCLK);
    #2 iReset_n = 1'b0;
    #1;
    n_total++; if (oValid !== 1'b0) $display("FAIL ar_valid: got %b want 0", oValid); else n_pass++;
    n_total++; if (oLevel !== 5'd0) $display("FAIL ar_level: got %0d want 0", oLevel); else n_pass++;
    n_total++; if ({oSyncErr, oOverflow, oFrameDone} !== 3'b000)
      $display("FAIL ar_flags: got %b want 000", {oSyncErr, oOverflow, oFrameDone}); else n_pass++;
    n_total++; if ({oSOF, oEOF, oAddr, oData} !== 36'd0)
      $display("FAIL ar_head: got %h want 0", {oSOF, oEOF, oAddr, oData}); else n_pass++;
    @(negedge iCLK); iReset_n = 1'b1; iReady = 1'b1; mon_q.delete();
    drive_pix(0, 1, 8'h90); drive_pix(1, 1, 8'h91);
    idle(5);
    n_total++; if (mon_q.size() !== 1) $display("FAIL ar_post_count: got %0d want 1", mon_q.size()); else n_pass++;
    n_total++; if (mon_q[0] !== {1'b0, 1'b0, 18'd0, 16'h9190})
      $display("FAIL ar_post_word: got %h want %h", mon_q[0], {1'b0, 1'b0, 18'd0, 16'h9190}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_push_pop_full();
    test_pairing();
    test_range_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
